presubaddor_acc_pipe: RTL and testbench

Parametrised pre-adder/subtractor multiply-accumulate pipeline computing ((d ± a) * b) + c, or accumulating (d ± a) * b into a running sum. It generalises the fixed 10-bit, 2-stage, unsigned pre-subtract multiply-add benchmark in three ways: configurable width, depth and signedness; a runtime add/sub mode; and a valid-qualified accumulate path. It is a DSP-mapping benchmark and integration-test design for the dsp template flow on the supported architectures.

---
 rtl/presubaddor_pkg.sv | 37 +++
 rtl/presubaddor_delay.sv | 44 ++++
 rtl/presubaddor_acc_pipe.sv | 108 ++++++++++
 tb/tb_presubaddor_acc_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/presubaddor_pkg.sv
// Shared types and helpers for the pre-add/sub multiply-accumulate pipeline.
// The clamp helper is only used when PRESUBADDOR_SAT_EN is defined.
package presubaddor_pkg;

   typedef enum logic {
      PREOP_SUB = 1'b0,
      PREOP_ADD = 1'b1
   } preop_e;

   localparam int SAT_MAX_W = 128;

   function automatic int pre_w(input int w);
      return w + 1;
   endfunction

   function automatic int prod_w(input int w);
      return 2 * w + 2;
   endfunction

   // Clamp a sign-extended accumulator into the w-bit signed or unsigned range
   function automatic logic [SAT_MAX_W-1:0] sat_clamp(
      input logic signed [SAT_MAX_W-1:0] v,
      input int                          w,
      input bit                          sgn
   );
      logic signed [SAT_MAX_W-1:0] one;
      logic signed [SAT_MAX_W-1:0] hi;
      logic signed [SAT_MAX_W-1:0] lo;
      one = 1;
      hi  = sgn ? (one <<< (w - 1)) - one : (one <<< w) - one;
      lo  = sgn ? -(one <<< (w - 1)) : '0;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/presubaddor_delay.sv
// Parametrised register chain with its own reset-cleared valid bit.
// DEPTH = 0 degenerates to a plain wire pass-through.
module presubaddor_delay #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_clk;
         assign unused_clk = clk ^ rst_n;
         assign out_valid  = in_valid;
         assign out_data   = in_data;
      end else begin : g_chain
         logic [DEPTH-1:0]  vld;
         logic [DATA_W-1:0] dat [DEPTH];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld <= '0;
               for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
            end else begin
               vld[0] <= in_valid;
               dat[0] <= in_data;
               for (int i = 1; i < DEPTH; i++) begin
                  vld[i] <= vld[i-1];
                  dat[i] <= dat[i-1];
               end
            end
         end

         assign out_valid = vld[DEPTH-1];
         assign out_data  = dat[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/presubaddor_acc_pipe.sv
// ((d +/- a) * b) + c multiply-add / accumulate pipeline, STAGES cycles deep.
// Define PRESUBADDOR_SAT_EN to clamp out instead of truncating it.
module presubaddor_acc_pipe
   import presubaddor_pkg::*;
#(
   parameter int WIDTH  = 10,
   parameter int STAGES = 2,
   parameter int SIGNED = 0,
   parameter int ACC_W  = 2 * WIDTH + 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             mode,
   input  logic             acc_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] out,
   output logic             out_valid
);

   localparam int PW = pre_w(WIDTH);
   localparam int MW = prod_w(WIDTH);
   localparam int BW = MW + PW + 1;

   logic signed [PW-1:0] a_x, b_x, c_x, d_x, pre;
   logic signed [MW-1:0] prod;

   assign a_x = (SIGNED != 0) ? {a[WIDTH-1], a} : {1'b0, a};
   assign b_x = (SIGNED != 0) ? {b[WIDTH-1], b} : {1'b0, b};
   assign c_x = (SIGNED != 0) ? {c[WIDTH-1], c} : {1'b0, c};
   assign d_x = (SIGNED != 0) ? {d[WIDTH-1], d} : {1'b0, d};

   assign pre  = (preop_e'(mode) == PREOP_ADD) ? d_x + a_x : d_x - a_x;
   assign prod = pre * b_x;

   logic                 f_valid;
   logic                 f_accm;
   logic signed [MW-1:0] f_prod;
   logic signed [PW-1:0] f_c;

   generate
      if (STAGES == 1) begin : g_comb
         assign f_valid = in_valid;
         assign f_accm  = acc_mode;
         assign f_prod  = prod;
         assign f_c     = c_x;
      end else begin : g_reg
         logic          s_valid;
         logic [BW-1:0] s_data;
         logic [BW-1:0] t_data;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s_valid <= 1'b0;
               s_data  <= '0;
            end else begin
               s_valid <= in_valid;
               if (in_valid) s_data <= {prod, c_x, acc_mode};
            end
         end

         presubaddor_delay #(
            .DATA_W (BW),
            .DEPTH  (STAGES - 2)
         ) u_delay (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (s_valid),
            .in_data   (s_data),
            .out_valid (f_valid),
            .out_data  (t_data)
         );

         assign {f_prod, f_c, f_accm} = t_data;
      end
   endgenerate

   logic signed [ACC_W-1:0] acc, prod_a, c_a;

   assign prod_a = ACC_W'(f_prod);
   assign c_a    = ACC_W'(f_c);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= f_valid;
         if (f_valid) acc <= f_accm ? acc + prod_a : prod_a + c_a;
      end
   end

`ifdef PRESUBADDOR_SAT_EN
   logic [SAT_MAX_W-1:0] sat;
   logic                 unused_sat;
   assign sat        = sat_clamp(SAT_MAX_W'(acc), WIDTH, SIGNED != 0);
   assign out        = sat[WIDTH-1:0];
   assign unused_sat = ^sat[SAT_MAX_W-1:WIDTH];
`else
   logic unused_hi;
   assign out       = acc[WIDTH-1:0];
   assign unused_hi = ^acc[ACC_W-1:WIDTH];
`endif

endmodule

// File: tb/tb_presubaddor_acc_pipe.sv
// Self-checking bench: directed and random beats against an arithmetic model.
// Honours PRESUBADDOR_SAT_EN for the expected output rule.
module tb_presubaddor_acc_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // main instance: WIDTH=10 STAGES=2 unsigned
   logic       m_valid = 0, m_mode = 0, m_accm = 0;
   logic [9:0] m_a = 0, m_b = 0, m_c = 0, m_d = 0;
   logic [9:0] m_out;
   logic       m_ov;

   presubaddor_acc_pipe #(.WIDTH(10), .STAGES(2), .SIGNED(0)) u_main (
      .clk(clk), .rst_n(rst_n), .in_valid(m_valid), .mode(m_mode),
      .acc_mode(m_accm), .a(m_a), .b(m_b), .c(m_c), .d(m_d),
      .out(m_out), .out_valid(m_ov)
   );

   // sweep instances: WIDTH=16 signed, STAGES 1/3/8
   logic        s_valid = 0, s_mode = 0, s_accm = 0;
   logic [15:0] s_a = 0, s_b = 0, s_c = 0, s_d = 0;
   logic [15:0] o1, o3, o8;
   logic        v1, v3, v8;

   presubaddor_acc_pipe #(.WIDTH(16), .STAGES(1), .SIGNED(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .mode(s_mode),
      .acc_mode(s_accm), .a(s_a), .b(s_b), .c(s_c), .d(s_d),
      .out(o1), .out_valid(v1)
   );
   presubaddor_acc_pipe #(.WIDTH(16), .STAGES(3), .SIGNED(1)) u_s3 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .mode(s_mode),
      .acc_mode(s_accm), .a(s_a), .b(s_b), .c(s_c), .d(s_d),
      .out(o3), .out_valid(v3)
   );
   presubaddor_acc_pipe #(.WIDTH(16), .STAGES(8), .SIGNED(1)) u_s8 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .mode(s_mode),
      .acc_mode(s_accm), .a(s_a), .b(s_b), .c(s_c), .d(s_d),
      .out(o8), .out_valid(v8)
   );

   // reference model: plain integer arithmetic on the stated rules
   function automatic longint wrap_s(longint v, int w);
      longint m = longint'(1) <<< w;
      longint r = v & (m - 1);
      if (r >= (m >>> 1)) r = r - m;
      return r;
   endfunction

   function automatic longint ext(longint v, int w, bit sgn);
      if (sgn && v >= (longint'(1) <<< (w - 1))) return v - (longint'(1) <<< w);
      return v;
   endfunction

   function automatic longint next_acc(longint acc, longint a, longint b,
                                       longint c, longint d, bit md, bit am,
                                       int w, bit sgn, int accw);
      longint pre, prod;
      pre  = wrap_s(md ? ext(d, w, sgn) + ext(a, w, sgn)
                       : ext(d, w, sgn) - ext(a, w, sgn), w + 1);
      prod = wrap_s(pre * ext(b, w, sgn), 2 * w + 2);
      return am ? wrap_s(acc + prod, accw) : wrap_s(prod + ext(c, w, sgn), accw);
   endfunction

   function automatic longint exp_out(longint acc, int w, bit sgn);
      longint r = acc;
`ifdef PRESUBADDOR_SAT_EN
      longint hi = sgn ? (longint'(1) <<< (w - 1)) - 1 : (longint'(1) <<< w) - 1;
      longint lo = sgn ? -(longint'(1) <<< (w - 1)) : 0;
      if (r > hi) r = hi;
      if (r < lo) r = lo;
`endif
      return r & ((longint'(1) <<< w) - 1);
   endfunction

   typedef struct {
      longint val;
      int     cyc;
   } exp_t;

   exp_t   q[$];
   longint macc = 0;

   always @(negedge clk) begin
      exp_t       e;
      logic [9:0] ev;
      if (rst_n && m_ov) begin
         if (q.size() == 0) begin
            total++;
            assert (m_ov === 1'b0) else begin
               bad++;
               $error("FAIL stray_pulse out_valid=%0b expected=0 out=%0d", m_ov, m_out);
            end
         end else begin
            e  = q.pop_front();
            ev = e.val[9:0];
            total++;
            assert (m_out === ev) else begin
               bad++;
               $error("FAIL out got=%0d expected=%0d", m_out, ev);
            end
            total++;
            assert ((cyc - e.cyc) === 2) else begin
               bad++;
               $error("FAIL latency got=%0d expected=2", cyc - e.cyc);
            end
         end
      end
   end

   task automatic beat(input bit v, input bit md, input bit am,
                       input logic [9:0] a, input logic [9:0] b,
                       input logic [9:0] c, input logic [9:0] d,
                       input bit fix, input longint fixv);
      exp_t e;
      @(posedge clk);
      #1;
      m_valid = v;
      m_mode  = md;
      m_accm  = am;
      m_a = a;
      m_b = b;
      m_c = c;
      m_d = d;
      if (v) begin
         macc  = next_acc(macc, a, b, c, d, md, am, 10, 1'b0, 24);
         e.val = fix ? fixv : exp_out(macc, 10, 1'b0);
         e.cyc = cyc;
         q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   longint sw_exp;
   int     lat1, lat3, lat8, cnt1, cnt3, cnt8, issue;
   logic [15:0] val1, val3, val8, sw_e16;

   initial begin
      #3;
      total++;
      assert (m_out === 10'd0) else begin
         bad++;
         $error("FAIL reset_out got=%0d expected=0", m_out);
      end
      total++;
      assert (m_ov === 1'b0) else begin
         bad++;
         $error("FAIL reset_valid got=%0b expected=0", m_ov);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // directed beats
      beat(1, 0, 0, 3, 5, 7, 10, 1, 42);
`ifdef PRESUBADDOR_SAT_EN
      beat(1, 1, 0, 0, 1023, 0, 1023, 1, 1023);
      beat(1, 0, 0, 5, 4, 0, 2, 1, 0);
`else
      beat(1, 1, 0, 0, 1023, 0, 1023, 1, 1);
      beat(1, 0, 0, 5, 4, 0, 2, 1, 1012);
`endif
      beat(1, 0, 0, 1, 2, 0, 4, 1, 6);
      beat(1, 0, 1, 1, 2, 0, 4, 1, 12);
      beat(1, 0, 1, 1, 2, 0, 4, 1, 18);
      idle(4);

      // randomized beats with gaps
      for (int i = 0; i < 80; i++)
         beat($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
              10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom), 0, 0);
      idle(4);
      total++;
      assert (q.size() === 0) else begin
         bad++;
         $error("FAIL drain pending=%0d expected=0", q.size());
      end

      // reset while a beat is in flight
      beat(1, 0, 0, 3, 5, 7, 10, 0, 0);
      @(posedge clk);
      #2;
      m_valid = 0;
      rst_n   = 1'b0;
      q.delete();
      macc = 0;
      #1;
      total++;
      assert (m_out === 10'd0) else begin
         bad++;
         $error("FAIL midrst_out got=%0d expected=0", m_out);
      end
      total++;
      assert (m_ov === 1'b0) else begin
         bad++;
         $error("FAIL midrst_valid got=%0b expected=0", m_ov);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(5);
      total++;
      assert (m_out === 10'd0) else begin
         bad++;
         $error("FAIL post_rst_out got=%0d expected=0", m_out);
      end

      // STAGES sweep, signed 16-bit
      sw_exp = exp_out(next_acc(0, 16'hFFF9, 16'hFFFE, 5, 3, 0, 0, 16, 1'b1, 36),
                       16, 1'b1);
      sw_e16 = sw_exp[15:0];
      lat1 = -1; lat3 = -1; lat8 = -1;
      cnt1 = 0;  cnt3 = 0;  cnt8 = 0;
      val1 = 0;  val3 = 0;  val8 = 0;
      @(posedge clk);
      #1;
      s_valid = 1;
      s_a = 16'hFFF9;
      s_b = 16'hFFFE;
      s_c = 16'd5;
      s_d = 16'd3;
      issue = cyc;
      @(posedge clk);
      #1;
      s_valid = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (v1) begin
            cnt1++;
            if (lat1 < 0) begin lat1 = cyc - issue; val1 = o1; end
         end
         if (v3) begin
            cnt3++;
            if (lat3 < 0) begin lat3 = cyc - issue; val3 = o3; end
         end
         if (v8) begin
            cnt8++;
            if (lat8 < 0) begin lat8 = cyc - issue; val8 = o8; end
         end
      end
      total++;
      assert (lat1 === 1) else begin bad++; $error("FAIL s1_lat got=%0d expected=1", lat1); end
      total++;
      assert (lat3 === 3) else begin bad++; $error("FAIL s3_lat got=%0d expected=3", lat3); end
      total++;
      assert (lat8 === 8) else begin bad++; $error("FAIL s8_lat got=%0d expected=8", lat8); end
      total++;
      assert (val1 === sw_e16) else begin bad++; $error("FAIL s1_out got=%0d expected=%0d", val1, sw_e16); end
      total++;
      assert (val3 === sw_e16) else begin bad++; $error("FAIL s3_out got=%0d expected=%0d", val3, sw_e16); end
      total++;
      assert (val8 === sw_e16) else begin bad++; $error("FAIL s8_out got=%0d expected=%0d", val8, sw_e16); end
      total++;
      assert (cnt1 === 1) else begin bad++; $error("FAIL s1_pulses got=%0d expected=1", cnt1); end
      total++;
      assert (cnt3 === 1) else begin bad++; $error("FAIL s3_pulses got=%0d expected=1", cnt3); end
      total++;
      assert (cnt8 === 1) else begin bad++; $error("FAIL s8_pulses got=%0d expected=1", cnt8); end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
